// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: VGA timing generator with selectable test patterns
// (solid colour, colour bars, checkerboard, grid).
// Optional feature: define VGA_PATTERN_SCROLL_EN to make the checkerboard
// scroll horizontally by one pixel per frame.
module vga_pattern_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned COLOR_BITS = 4,
  parameter int unsigned CLK_DIV    = 2,
  localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HW = $clog2(HT),
  localparam int unsigned VW = $clog2(VT),
  localparam int unsigned CW = 3 * COLOR_BITS
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic [1:0]            MODE,
  input  logic [CW-1:0]         FG_COLOR,
  output logic [COLOR_BITS-1:0] VGA_RED,
  output logic [COLOR_BITS-1:0] VGA_GREEN,
  output logic [COLOR_BITS-1:0] VGA_BLUE,
  output logic                  VGA_HS,
  output logic                  VGA_VS,
  output logic                  VGA_DE,
  output logic [HW-1:0]         PIX_X,
  output logic [VW-1:0]         PIX_Y,
  output logic                  FRAME_START
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(HT - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(VT - 1);
  localparam logic [COLOR_BITS-1:0] ONES = '1;

  logic [DW-1:0]         div_cnt;
  logic                  pix_en;
  logic [HW-1:0]         h_cnt;
  logic [VW-1:0]         v_cnt;
  logic [1:0]            mode_q;
  logic [CW-1:0]         fg_q;
  logic                  frame_origin;
  logic                  check_h;
  logic                  check_v;
  logic [1:0]            cur_mode;
  logic [CW-1:0]         cur_fg;
  logic                  active;
  logic                  hs_on;
  logic                  vs_on;
  logic                  grid;
  logic [2:0]            bar_col;
  logic [COLOR_BITS-1:0] red_c;
  logic [COLOR_BITS-1:0] green_c;
  logic [COLOR_BITS-1:0] blue_c;

  assign pix_en       = (div_cnt == DIV_LAST);
  assign frame_origin = (h_cnt == '0) && (v_cnt == '0);
  assign check_v      = 1'(32'(v_cnt) >> 3);

  // Pixel clock divider: one enable every CLK_DIV clocks.
  always_ff @(posedge CLOCK_50) begin
    if (RESET || pix_en) div_cnt <= '0;
    else                 div_cnt <= div_cnt + DW'(1);
  end

  // Horizontal and vertical position counters.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

`ifdef VGA_PATTERN_SCROLL_EN
  logic [7:0] frame_cnt;

  // Frame counter driving the checkerboard scroll offset.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) frame_cnt <= '0;
    else if (pix_en && h_cnt == H_LAST && v_cnt == V_LAST) frame_cnt <= frame_cnt + 8'd1;
  end

  assign check_h = 1'((32'(h_cnt) + 32'(frame_cnt)) >> 3);
`else
  assign check_h = 1'(32'(h_cnt) >> 3);
`endif

  // Pattern settings are captured at the frame origin so a frame never tears.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      mode_q <= '0;
      fg_q   <= '0;
    end else if (pix_en && frame_origin) begin
      mode_q <= MODE;
      fg_q   <= FG_COLOR;
    end
  end

  // Pixel colour and sync decode for the current counter position.
  always_comb begin
    red_c    = '0;
    green_c  = '0;
    blue_c   = '0;
    cur_mode = frame_origin ? MODE : mode_q;
    cur_fg   = frame_origin ? FG_COLOR : fg_q;
    active   = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    hs_on    = (32'(h_cnt) >= H_ACTIVE + H_FP) && (32'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
    vs_on    = (32'(v_cnt) >= V_ACTIVE + V_FP) && (32'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);
    bar_col  = 3'd7 - 3'((32'(h_cnt) * 32'd8) / H_ACTIVE);
    grid     = (4'(h_cnt) == 4'd0) || (4'(v_cnt) == 4'd0) ||
               (32'(h_cnt) == H_ACTIVE - 1) || (32'(v_cnt) == V_ACTIVE - 1);
    if (active) begin
      case (cur_mode)
        2'd0: {red_c, green_c, blue_c} = cur_fg;
        2'd1: begin
          red_c   = bar_col[2] ? ONES : '0;
          green_c = bar_col[1] ? ONES : '0;
          blue_c  = bar_col[0] ? ONES : '0;
        end
        2'd2: if (!(check_h ^ check_v)) {red_c, green_c, blue_c} = cur_fg;
        default: if (grid) {red_c, green_c, blue_c} = {ONES, ONES, ONES};
      endcase
    end
  end

  // Registered video outputs, one pixel behind the counters.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      VGA_RED     <= '0;
      VGA_GREEN   <= '0;
      VGA_BLUE    <= '0;
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
      VGA_DE      <= 1'b0;
      PIX_X       <= '0;
      PIX_Y       <= '0;
      FRAME_START <= 1'b0;
    end else begin
      FRAME_START <= 1'b0;
      if (pix_en) begin
        VGA_RED     <= red_c;
        VGA_GREEN   <= green_c;
        VGA_BLUE    <= blue_c;
        VGA_HS      <= hs_on ? HS_POL : ~HS_POL;
        VGA_VS      <= vs_on ? VS_POL : ~VS_POL;
        VGA_DE      <= active;
        PIX_X       <= h_cnt;
        PIX_Y       <= v_cnt;
        FRAME_START <= frame_origin;
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: scoreboard bench for vga_pattern_gen. Two instances
// (small divided-clock config and a larger CLK_DIV=1, positive-sync config)
// share stimulus; a reference model predicts every clock's outputs.
`timescale 1ns/1ps
module tb_vga_pattern_gen;

  typedef struct packed {
    logic [7:0]  r, g, b;
    logic        hs, vs, de, fs;
    logic [15:0] x, y;
  } out_t;

  localparam int P_HA = 0, P_HF = 1, P_HS = 2, P_HB = 3, P_VA = 4, P_VF = 5,
                 P_VS = 6, P_VB = 7, P_CD = 8, P_POL = 9;

  function automatic int cfg(int c, int i);
    int a [10];
    if (c == 0) a = '{8, 2, 2, 2, 4, 1, 1, 1, 2, 0};
    else        a = '{24, 4, 4, 4, 20, 2, 2, 2, 1, 1};
    return a[i];
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  mode;
  logic [11:0] fg;

  logic [3:0] red_a, grn_a, blu_a, red_b, grn_b, blu_b;
  logic       hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b;
  logic [3:0] px_a;
  logic [2:0] py_a;
  logic [5:0] px_b;
  logic [4:0] py_b;

  vga_pattern_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_BITS(4), .CLK_DIV(2)
  ) dut_a (
    .CLOCK_50(clk), .RESET(rst), .MODE(mode), .FG_COLOR(fg),
    .VGA_RED(red_a), .VGA_GREEN(grn_a), .VGA_BLUE(blu_a),
    .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_DE(de_a),
    .PIX_X(px_a), .PIX_Y(py_a), .FRAME_START(fs_a)
  );

  vga_pattern_gen #(
    .H_ACTIVE(24), .H_FP(4), .H_SYNC(4), .H_BP(4),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_BITS(4), .CLK_DIV(1)
  ) dut_b (
    .CLOCK_50(clk), .RESET(rst), .MODE(mode), .FG_COLOR(fg),
    .VGA_RED(red_b), .VGA_GREEN(grn_b), .VGA_BLUE(blu_b),
    .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_DE(de_b),
    .PIX_X(px_b), .PIX_Y(py_b), .FRAME_START(fs_b)
  );

  out_t obs_a, obs_b;
  assign obs_a = {8'(red_a), 8'(grn_a), 8'(blu_a), hs_a, vs_a, de_a, fs_a, 16'(px_a), 16'(py_a)};
  assign obs_b = {8'(red_b), 8'(grn_b), 8'(blu_b), hs_b, vs_b, de_b, fs_b, 16'(px_b), 16'(py_b)};

  // Reference model state per configuration.
  int          k     [2];
  out_t        held  [2];
  logic [1:0]  fmode [2];
  logic [11:0] ffg   [2];
  out_t        q0 [$];
  out_t        q1 [$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  bit          active = 1'b0;
  logic [1:0]  d_mode;
  logic [11:0] d_fg;

  function automatic int ht(int c);
    return cfg(c, P_HA) + cfg(c, P_HF) + cfg(c, P_HS) + cfg(c, P_HB);
  endfunction

  function automatic int vt(int c);
    return cfg(c, P_VA) + cfg(c, P_VF) + cfg(c, P_VS) + cfg(c, P_VB);
  endfunction

  function automatic int cur_x(int c);
    return (k[c] / cfg(c, P_CD)) % ht(c);
  endfunction

  function automatic int cur_y(int c);
    return ((k[c] / cfg(c, P_CD)) / ht(c)) % vt(c);
  endfunction

  function automatic out_t reset_rec(int c);
    out_t o = '0;
    o.hs = (cfg(c, P_POL) == 0);
    o.vs = (cfg(c, P_POL) == 0);
    return o;
  endfunction

  // Expected output for pixel (x,y) of frame f, straight from the pattern rules.
  function automatic out_t pix_val(int c, int x, int y, int f, logic [1:0] m, logic [11:0] col);
    out_t o = '0;
    int   ha = cfg(c, P_HA);
    int   va = cfg(c, P_VA);
    int   pol = cfg(c, P_POL);
    int   bar, sx, sh;
    bit   hs_act, vs_act;
    hs_act = (x >= ha + cfg(c, P_HF)) && (x < ha + cfg(c, P_HF) + cfg(c, P_HS));
    vs_act = (y >= va + cfg(c, P_VF)) && (y < va + cfg(c, P_VF) + cfg(c, P_VS));
    o.hs = hs_act ? (pol == 1) : (pol == 0);
    o.vs = vs_act ? (pol == 1) : (pol == 0);
    o.de = (x < ha) && (y < va);
    o.fs = (x == 0) && (y == 0);
    o.x  = 16'(x);
    o.y  = 16'(y);
    if (o.de) begin
      case (m)
        2'd0: begin o.r = 8'(col[11:8]); o.g = 8'(col[7:4]); o.b = 8'(col[3:0]); end
        2'd1: begin
          bar = 7 - (x * 8) / ha;
          o.r = ((bar / 4) % 2 == 1) ? 8'hF : 8'h0;
          o.g = ((bar / 2) % 2 == 1) ? 8'hF : 8'h0;
          o.b = (bar % 2 == 1)       ? 8'hF : 8'h0;
        end
        2'd2: begin
          sh = 0;
`ifdef VGA_PATTERN_SCROLL_EN
          sh = f;
`endif
          sx = x + sh;
          if (((sx / 8) + (y / 8)) % 2 == 0) begin
            o.r = 8'(col[11:8]); o.g = 8'(col[7:4]); o.b = 8'(col[3:0]);
          end
        end
        default: begin
          if (x % 16 == 0 || y % 16 == 0 || x == ha - 1 || y == va - 1) begin
            o.r = 8'hF; o.g = 8'hF; o.b = 8'hF;
          end
        end
      endcase
    end
    return o;
  endfunction

  // Advance the model by one clock edge with the inputs now being applied.
  task automatic model_edge(int c);
    int cd = cfg(c, P_CD);
    int n, x, y, f;
    if (rst) begin
      k[c]    = 0;
      held[c] = reset_rec(c);
    end else begin
      held[c].fs = 1'b0;
      if (k[c] % cd == cd - 1) begin
        n = k[c] / cd;
        x = n % ht(c);
        y = (n / ht(c)) % vt(c);
        f = n / (ht(c) * vt(c));
        if (x == 0 && y == 0) begin
          fmode[c] = mode;
          ffg[c]   = fg;
        end
        held[c] = pix_val(c, x, y, f, fmode[c], ffg[c]);
      end
      k[c]++;
    end
    if (c == 0) q0.push_back(held[c]);
    else        q1.push_back(held[c]);
  endtask

  // Apply inputs on the falling edge, record expectations, wait for the rising edge.
  task automatic tick(bit r);
    @(negedge clk);
    rst  = r;
    mode = d_mode;
    fg   = d_fg;
    model_edge(0);
    model_edge(1);
    active = 1'b1;
    cyc++;
    @(posedge clk);
  endtask

  task automatic check(int c);
    out_t e, g;
    n_cmp++;
    if ((c == 0 && q0.size() == 0) || (c == 1 && q1.size() == 0)) begin
      n_bad++;
      $display("FAIL cfg%0d cycle %0d: scoreboard empty, got output with no expected entry", c, cyc);
      return;
    end
    e = (c == 0) ? q0.pop_front() : q1.pop_front();
    g = (c == 0) ? obs_a : obs_b;
    if (g !== e) begin
      n_bad++;
      $display("FAIL cfg%0d cycle %0d: got rgb=%h/%h/%h hs=%b vs=%b de=%b fs=%b x=%0d y=%0d, expected rgb=%h/%h/%h hs=%b vs=%b de=%b fs=%b x=%0d y=%0d",
               c, cyc, g.r, g.g, g.b, g.hs, g.vs, g.de, g.fs, g.x, g.y,
               e.r, e.g, e.b, e.hs, e.vs, e.de, e.fs, e.x, e.y);
    end
  endtask

  // Monitor: compare every observed output against the scoreboard.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (active) begin
        check(0);
        check(1);
      end
    end
  end

  // Stimulus.
  initial begin
    rst    = 1'b1;
    mode   = 2'd0;
    fg     = 12'h000;
    d_mode = 2'd0;
    d_fg   = 12'hF00;
    for (int c = 0; c < 2; c++) begin
      k[c] = 0; fmode[c] = 2'd0; ffg[c] = 12'h000; held[c] = reset_rec(c);
    end

    // Reset, then free run two frames of solid red.
    repeat (3) tick(1'b1);
    repeat (2 * 196) tick(1'b0);

    // Colour bars.
    d_mode = 2'd1;
    repeat (196) tick(1'b0);

    // Solid, then switch to checkerboard mid-frame on line 2.
    d_mode = 2'd0;
    for (int i = 0; i < 400 && !(cur_x(0) == 0 && cur_y(0) == 1); i++) tick(1'b0);
    for (int i = 0; i < 400 && cur_y(0) != 2; i++) tick(1'b0);
    d_mode = 2'd2;
    repeat (2 * 196) tick(1'b0);

    // One-clock reset mid-frame at (5,3).
    for (int i = 0; i < 400 && !(cur_x(0) == 5 && cur_y(0) == 3); i++) tick(1'b0);
    tick(1'b1);
    repeat (60) tick(1'b0);

    // Grid.
    d_mode = 2'd3;
    repeat (1000) tick(1'b0);

    // Randomized pattern, colour and reset activity.
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 39) == 0) d_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) d_fg = 12'($urandom);
      tick($urandom_range(0, 799) == 0);
    end

    @(negedge clk);
    active = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
